ram_access_arbiter: RTL

- Shares the CPU's 16x8 program/data RAM between two requesters:
  - the CPU control sequencer, which issues per-cycle active-low RAM strobes;
  - an external program loader/debugger, which uses a 4-phase req/ack handshake.
- The CPU has priority. The loader is granted only on idle bus cycles, or after a bounded starvation wait.
- While the loader owns the bus, cpu_stall freezes the control sequencer's stage counter.

---
 rtl/ram_access_arbiter_if.sv | 46 ++++
 rtl/ram_access_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter_if.sv
// Bus bundle between the CPU sequencer, the program loader, the RAM and the
// arbiter.
//   slave  : arbiter view (CPU/loader requests and ram_rdata in; RAM strobes,
//            ld_ack, ld_rdata, cpu_rdata and cpu_stall out)
//   master : environment view (the mirror of slave)
interface ram_access_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  // CPU control sequencer side
  logic              cpu_ram_en_n;
  logic              cpu_ram_load_n;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  // Loader / debugger side, 4-phase req/ack
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ack;
  logic [DATA_W-1:0] ld_rdata;
  // RAM side
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ce_n;
  logic              ram_we_n;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_ram_en_n, cpu_ram_load_n, cpu_addr, cpu_wdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  ram_rdata,
    output cpu_rdata, cpu_stall, ld_ack, ld_rdata,
    output ram_addr, ram_wdata, ram_ce_n, ram_we_n
  );

  modport master (
    output cpu_ram_en_n, cpu_ram_load_n, cpu_addr, cpu_wdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    output ram_rdata,
    input  cpu_rdata, cpu_stall, ld_ack, ld_rdata,
    input  ram_addr, ram_wdata, ram_ce_n, ram_we_n
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Shares the CPU program/data RAM between the CPU control sequencer (priority,
// per-cycle active-low strobes) and an external loader (4-phase req/ack).
// The loader is granted on idle bus cycles or after STARVE_LIMIT consecutive
// denied cycles; cpu_stall freezes the sequencer while the loader owns the bus.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   bus (slave)     : CPU, loader and RAM signals, see ram_access_arbiter_if
//   grant_cnt       : loader grant counter   (only with ARB_STATS_EN)
//   stall_cnt       : cpu_stall cycle counter (only with ARB_STATS_EN)
// Optional feature macro: ARB_STATS_EN.
module ram_access_arbiter #(
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_access_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]           grant_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int unsigned WAIT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int unsigned ACC_W  = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LD_ACCESS = 2'd1,
    LD_ACK    = 2'd2,
    LD_WAIT   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [ACC_W-1:0]    acc_cnt_q, acc_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic cpu_acc;
  logic starved;

  assign cpu_acc = !bus.cpu_ram_en_n || !bus.cpu_ram_load_n;
  // wait_cnt saturates at STARVE_LIMIT, so equality marks starvation
  assign starved = (wait_cnt_q == WAIT_W'(STARVE_LIMIT));

  // Next-state, latches and RAM steering
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    acc_cnt_d     = acc_cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    we_d          = we_q;
    rdata_d       = rdata_q;
    bus.ram_addr  = bus.cpu_addr;
    bus.ram_wdata = bus.cpu_wdata;
    bus.ram_ce_n  = bus.cpu_ram_en_n;
    bus.ram_we_n  = bus.cpu_ram_load_n;

    case (state_q)
      IDLE: begin
        if (bus.ld_req && (!cpu_acc || starved)) begin
          addr_d     = bus.ld_addr;
          wdata_d    = bus.ld_wdata;
          we_d       = bus.ld_we;
          acc_cnt_d  = '0;
          wait_cnt_d = '0;
          state_d    = LD_ACCESS;
        end else if (bus.ld_req) begin
          if (!starved) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      LD_ACCESS: begin
        bus.ram_addr  = addr_q;
        bus.ram_wdata = wdata_q;
        bus.ram_ce_n  = 1'b0;
        bus.ram_we_n  = !we_q;
        if (acc_cnt_q == ACC_W'(ACCESS_CYCLES - 1)) begin
          if (!we_q) rdata_d = bus.ram_rdata;
          state_d = LD_ACK;
        end else begin
          acc_cnt_d = acc_cnt_q + ACC_W'(1);
        end
      end
      LD_ACK: begin
        bus.ram_addr  = addr_q;
        bus.ram_wdata = wdata_q;
        bus.ram_ce_n  = 1'b1;
        bus.ram_we_n  = 1'b1;
        state_d       = bus.ld_req ? LD_WAIT : IDLE;
      end
      LD_WAIT: begin
        if (!bus.ld_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      acc_cnt_q  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
    end
  end

  // Handshake outputs decode registered state only
  assign bus.ld_ack    = (state_q == LD_ACK) || (state_q == LD_WAIT);
  assign bus.cpu_stall = (state_q == LD_ACCESS) || (state_q == LD_ACK);
  assign bus.ld_rdata  = rdata_q;
  assign bus.cpu_rdata = bus.ram_rdata;

`ifdef ARB_STATS_EN
  logic grant;
  assign grant = (state_q == IDLE) && (state_d == LD_ACCESS);

  // Saturating grant / stall statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (grant && (grant_cnt != 16'hFFFF))         grant_cnt <= grant_cnt + 16'd1;
      if (bus.cpu_stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
